alu_control_md: RTL
===================

// Module: alu_control_md
// PURPOSE
//  Second-generation ALU control for the MIPS core. Decodes alu_op/func_code into
//  the 4-bit ALU select for single-cycle ops, the same as the current ALU control.
//  Adds an iterative multiply/divide unit (MULT/MULTU/DIV/DIVU) with HI/LO registers.
//  Also adds busy/stall outputs so the pipeline holds while a mul/div is in flight.
//  Sits between decode and the EX stage; HI/LO feed the MFHI/MFLO writeback mux.
// PARAMETERS
//  WIDTH   32  operand width; mul/div iterate WIDTH times; HI/LO are WIDTH each
//  CTRL_W  4   width of alu_signal
// PORTS
//  clk         in   1        single clock, all state on rising edge
//  reset       in   1        synchronous, active-high
//  valid       in   1        instruction in decode is real (not a bubble)
//  alu_op      in   2        00 lw/sw/addi, 01 beq, 10 R-type, 11 reserved
//  func_code   in   6        R-type funct field
//  op_a        in   WIDTH    rs value (dividend / multiplicand)
//  op_b        in   WIDTH    rt value (divisor / multiplier)
//  alu_signal  out  CTRL_W   ALU select (combinational)
//  illegal     out  1        unrecognised alu_op/funct (combinational)
//  busy        out  1        mul/div in progress
//  stall       out  1        hold pipeline (combinational)
//  done        out  1        one-cycle pulse: HI/LO just updated
//  div_zero    out  1        one-cycle pulse with done: divide by zero
//  hi, lo      out  WIDTH    HI/LO registers
// BEHAVIOUR
//  Decode (combinational):
//   - alu_op 00 -> 0010; alu_op 01 -> 0110.
//   - alu_op 10: funct 100000 add=0010, 100010 sub=0110, 100100 and=0000,
//     100101 or=0001, 100111 nor=1100, 101010 slt=0111.
//   - alu_op 10 with mul/div/mfhi/mflo funct -> 1111, illegal=0.
//   - Any other funct, or alu_op 11 -> 1111 and illegal=1. Never X/Z.
//   - Mul/div functs: 011000 mult, 011001 multu, 011010 div, 011011 divu,
//     010000 mfhi, 010010 mflo.
//  Accept: valid & alu_op==10 & mul/div funct & state==IDLE.
//   - On that edge, latch op_a/op_b magnitudes (unsigned ops: raw) and the result signs.
//   - Clear the iteration counter; go to MUL or DIV.
//  FSM: IDLE -> MUL|DIV -> FIX -> IDLE.
//   - MUL: shift-add, one multiplier bit per cycle, WIDTH cycles.
//   - DIV: restoring, one quotient bit per cycle, WIDTH cycles.
//   - FIX: one cycle; apply sign correction, write hi/lo, assert done.
//  Latency: accept on edge 0; hi/lo and done are updated on edge WIDTH+1.
//   - busy is high from after edge 0 until edge WIDTH+1.
//   - done is high for the single cycle after edge WIDTH+1.
//  Results:
//   - MULT/MULTU: {hi,lo} = full 2*WIDTH product.
//   - DIV/DIVU: lo = quotient, truncated toward zero; hi = remainder, sign of dividend.
//   - DIV of MIN_INT by -1: lo = MIN_INT, hi = 0 (wrap, no trap).
//  Divide by zero (op_b==0 at accept):
//   - Skip iteration: next edge gives done=1, div_zero=1, state IDLE.
//   - hi/lo unchanged.
//  stall = valid & alu_op==10 & (mul/div/mfhi/mflo funct) & (busy | FIX).
//   - A mul/div presented while busy is NOT accepted; it is accepted on the first
//     idle cycle while still presented.
//  hi/lo hold their value except when written in FIX.
//  Reset: takes effect at any time, including mid-operation.
//   - Next edge: state IDLE, counter 0, hi=lo=0, busy=done=div_zero=0.
//   - Any in-flight result is discarded.
// STRUCTURE
//  Package alu_ctrl_pkg:
//   - ALU_ADD/SUB/AND/OR/NOR/SLT/NOP code localparams.
//   - ALUOP_* and FN_* funct constants.
//   - FSM state enum.
//  Sub-module muldiv_iter: iterative datapath (acc/quotient shift regs, counter,
//  sign fix), driven by the FSM in this module.
// TESTING
//  1. Decode sweep, valid=1 -> 00:0010, 01:0110, 10/100010:0110, 10/101010:0111,
//     10/111111:1111+illegal, 11:1111+illegal.
//  2. MULT a=-3 b=5 -> done at cycle 34 after accept; hi=FFFFFFFF lo=FFFFFFF1;
//     MULTU same operands -> hi=00000004 lo=FFFFFFF1.
//  3. DIVU 100/7 -> lo=14 hi=2. DIV -7/2 -> lo=FFFFFFFD hi=FFFFFFFF.
//     DIV 80000000/FFFFFFFF -> lo=80000000 hi=0.
//  4. Preload hi/lo, then DIV x/0 -> done+div_zero the next cycle; hi/lo unchanged;
//     busy never rises.
//  5. MFLO or a second MULT presented during busy -> stall=1 every cycle until done.
//     Second MULT accepted the cycle after done; first result intact.
//  6. Assert reset at cycle 10 of a MULT -> busy=0, hi=lo=0 next cycle; no done pulse.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl_pkg
//  Description : Shared ALU select codes, alu_op / funct encodings and the
//                multiply/divide sequencer state type.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_ctrl_pkg;

    // ALU select codes driven on alu_signal
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_NOP = 4'b1111;

    // alu_op encodings from the main decoder
    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BEQ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    // R-type funct codes
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;

    // Multiply/divide sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_t;

    // True for the four functs that start an iterative operation
    function automatic logic is_md_start(input logic [5:0] fn);
        return (fn == FN_MULT) || (fn == FN_MULTU) || (fn == FN_DIV) || (fn == FN_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_iter
//  Description : Iterative shift-add multiplier / restoring divider working on
//                operand magnitudes, with a final sign correction. Sequenced
//                by the owning FSM through load_i / step_i.
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_iter
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             div_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    // acc_q: multiply -> {partial product, remaining multiplier bits}
    //        divide   -> {partial remainder, dividend/quotient shift reg}
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q;       // multiplicand or divisor magnitude
    logic [CNT_W-1:0]   cnt_q;
    logic               div_q;
    logic               neg_lo_q;     // product / quotient must be negated
    logic               neg_hi_q;     // remainder must be negated

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] prod_fix;

    // Operand magnitudes; unsigned ops pass raw values through
    always_comb begin
        a_neg = signed_i & op_a_i[WIDTH-1];
        b_neg = signed_i & op_b_i[WIDTH-1];
        mag_a = a_neg ? (WIDTH'(0) - op_a_i) : op_a_i;
        mag_b = b_neg ? (WIDTH'(0) - op_b_i) : op_b_i;
    end

    // One iteration of either algorithm
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        // Only used when div_shift >= divisor, so the result fits in WIDTH bits
        div_diff  = div_shift[WIDTH-1:0] - opnd_q;
        if (div_q) begin
            if (div_shift >= {1'b0, opnd_q})
                acc_d = {div_diff, acc_q[WIDTH-2:0], 1'b1};
            else
                acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    // Iteration registers: load on accept, advance one bit per step
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
        end else if (load_i) begin
            cnt_q    <= '0;
            div_q    <= div_i;
            neg_lo_q <= a_neg ^ b_neg;
            neg_hi_q <= a_neg;
            if (div_i) begin
                acc_q  <= {{WIDTH{1'b0}}, mag_a};
                opnd_q <= mag_b;
            end else begin
                acc_q  <= {{WIDTH{1'b0}}, mag_b};
                opnd_q <= mag_a;
            end
        end else if (step_i) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Sign correction; MIN_INT / -1 wraps naturally through two's complement
    always_comb begin
        last_o   = (cnt_q == CNT_W'(WIDTH - 1));
        prod_fix = neg_lo_q ? ((2*WIDTH)'(0) - acc_q) : acc_q;
        if (div_q) begin
            lo_o = neg_lo_q ? (WIDTH'(0) - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
            hi_o = neg_hi_q ? (WIDTH'(0) - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
        end else begin
            lo_o = prod_fix[WIDTH-1:0];
            hi_o = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_control_md.sv
`default_nettype none
// ============================================================================
//  Module      : alu_control_md
//  Description : ALU control decode plus iterative MULT/MULTU/DIV/DIVU unit
//                with HI/LO registers and pipeline busy/stall handshaking.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_control_md
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        func_code,
    input  logic [WIDTH-1:0]  op_a,
    input  logic [WIDTH-1:0]  op_b,
    output logic [CTRL_W-1:0] alu_signal,
    output logic              illegal,
    output logic              busy,
    output logic              stall,
    output logic              done,
    output logic              div_zero,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo
);

    md_state_t        state_q, state_d;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q, div_zero_q;

    logic [3:0]       sel;
    logic             is_md, is_mf, fn_div, fn_signed;
    logic             accept, zero_div;
    logic             load, step, last;
    logic [WIDTH-1:0] res_hi, res_lo;

    // Funct/alu_op decode; anything unrecognised falls to NOP + illegal
    always_comb begin
        sel       = ALU_NOP;
        illegal   = 1'b1;
        is_md     = is_md_start(func_code);
        is_mf     = (func_code == FN_MFHI) || (func_code == FN_MFLO);
        fn_div    = (func_code == FN_DIV) || (func_code == FN_DIVU);
        fn_signed = (func_code == FN_MULT) || (func_code == FN_DIV);
        case (alu_op)
            ALUOP_MEM: begin sel = ALU_ADD; illegal = 1'b0; end
            ALUOP_BEQ: begin sel = ALU_SUB; illegal = 1'b0; end
            ALUOP_RTYPE: begin
                illegal = 1'b0;
                case (func_code)
                    FN_ADD:  sel = ALU_ADD;
                    FN_SUB:  sel = ALU_SUB;
                    FN_AND:  sel = ALU_AND;
                    FN_OR:   sel = ALU_OR;
                    FN_NOR:  sel = ALU_NOR;
                    FN_SLT:  sel = ALU_SLT;
                    default: begin
                        sel     = ALU_NOP;
                        illegal = !(is_md || is_mf);
                    end
                endcase
            end
            default: begin sel = ALU_NOP; illegal = 1'b1; end
        endcase
        alu_signal = CTRL_W'(sel);
    end

    // Sequencer next state; a zero divisor completes without leaving IDLE
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        step     = 1'b0;
        accept   = valid && (alu_op == ALUOP_RTYPE) && is_md && (state_q == ST_IDLE);
        zero_div = accept && fn_div && (op_b == '0);
        case (state_q)
            ST_IDLE: begin
                if (accept && !zero_div) begin
                    load    = 1'b1;
                    state_d = fn_div ? ST_DIV : ST_MUL;
                end
            end
            ST_MUL, ST_DIV: begin
                step = 1'b1;
                if (last) state_d = ST_FIX;
            end
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy  = (state_q != ST_IDLE);
        stall = valid && (alu_op == ALUOP_RTYPE) && (is_md || is_mf) &&
                (busy || (state_q == ST_FIX));
    end

    // State, HI/LO and completion pulses; reset discards any in-flight op
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_q     <= (state_q == ST_FIX) || zero_div;
            div_zero_q <= zero_div;
            if (state_q == ST_FIX) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end
    end

    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv_iter (
        .clk      (clk),
        .reset    (reset),
        .load_i   (load),
        .step_i   (step),
        .div_i    (fn_div),
        .signed_i (fn_signed),
        .op_a_i   (op_a),
        .op_b_i   (op_b),
        .last_o   (last),
        .hi_o     (res_hi),
        .lo_o     (res_lo)
    );

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;

endmodule
`default_nettype wire
